cycle_terminator: RTL
=====================

CYCLE_TERMINATOR -- requirements
Module: cycle_terminator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, nrst.
REQ-002 Parameter ADDRESS, default 1'b0, mode value for the addressing phase.
REQ-003 Parameter INSTRUCTION, default 1'b1, mode value for the execution phase.
REQ-004 Ports SHALL be exactly:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- enableFFs  in  1  global advance enable; low freezes the whole core
- mode  in  1  current phase from the sequencer
- timeState  in  3  current cycle, T0..T6 = 0..6
- currentAddress  in  4  latched addressing-mode code
- instrLastT  in  3  last T of the current instruction, from the decoder table
- pageCross  in  1  indexed-address carry out of the low byte, valid in the current cycle
- dataBus  in  8  read data bus
- noAddressing  out  1  skip addressing, go to instruction T0
- endAddressing  out  1  last addressing cycle
- getInstruction  out  1  last instruction cycle; the sequencer latches the next opcode
- opcodeReg  out  8  last fetched opcode byte
- sync  out  1  opcode fetch cycle indicator
- seqError  out  1  sticky sequencing fault

Function
REQ-005 Addressing codes SHALL be: 0 IMPLIED, 1 ACCUM, 2 IMM, 3 ZPG, 4 ZPG_X, 5 ZPG_Y, 6 ABS, 7 ABS_X, 8 ABS_Y, 9 IND, 10 IND_X, 11 IND_Y, 12 REL, 13-15 reserved.
REQ-006 Base last addressing T SHALL be: IMM/ZPG/REL T0; ZPG_X/ZPG_Y/ABS/ABS_X/ABS_Y T1; IND_Y T2; IND/IND_X T3.
REQ-007 noAddressing SHALL be combinational, asserting when mode==ADDRESS, timeState==T0 and currentAddress is IMPLIED, ACCUM or reserved.
REQ-008 endAddressing SHALL assert when mode==ADDRESS and timeState equals the base last T, except in the case covered by REQ-009.
REQ-009 Indexed modes (ABS_X, ABS_Y, IND_Y) with pageCross=1 at the base last T SHALL suppress endAddressing and set the extraPending register when enableFFs=1. While extraPending=1, endAddressing SHALL assert on the next cycle, and extraPending SHALL clear on that cycle when enableFFs=1.
REQ-010 getInstruction SHALL assert when mode==INSTRUCTION and timeState==instrLastT.
REQ-011 A watchdog SHALL force the terminating output whenever timeState==T6 and the normal condition is false: endAddressing in ADDRESS mode, getInstruction in INSTRUCTION mode. In that cycle seqError SHALL set if enableFFs=1.
REQ-012 seqError SHALL also set when noAddressing asserts because currentAddress is reserved (13-15) and enableFFs=1.
REQ-013 seqError SHALL be sticky and clear only on reset.
REQ-014 opcodeReg SHALL load dataBus on the rising clk edge when getInstruction=1 and enableFFs=1, and SHALL hold otherwise.
REQ-015 sync SHALL equal getInstruction, combinational.
REQ-016 When enableFFs=0, all registers (extraPending, opcodeReg, seqError) SHALL hold, while combinational outputs continue to reflect the inputs.
REQ-017 endAddressing and noAddressing SHALL never be asserted together with getInstruction, because the mode-qualified decode makes them mutually exclusive.
REQ-018 pageCross SHALL be ignored for non-indexed modes and outside the base last T.

Reset
REQ-019 nrst=0 SHALL asynchronously force opcodeReg=8'h00, extraPending=0 and seqError=0.
REQ-020 Combinational outputs SHALL follow their inputs during reset. With sequencer reset values (ADDRESS, T0, code 0), noAddressing=1 and the other two terminating outputs=0.
REQ-021 Reset asserted mid-extra-cycle SHALL discard the pending extra cycle; endAddressing SHALL then follow REQ-008 with a clear extraPending.

Verification
REQ-022 mode=ADDRESS, T0, currentAddress=0 -> noAddressing=1, endAddressing=0, seqError stays 0.
REQ-023 ABS_X, T1, pageCross=1, enableFFs=1 -> T1 gives endAddressing=0; next cycle at T2 gives endAddressing=1; following cycle extraPending=0.
REQ-024 INSTRUCTION mode, instrLastT=3, T3, dataBus=8'hA9 -> getInstruction=1 and sync=1; opcodeReg=8'hA9 after the edge.
REQ-025 Same as REQ-024 but enableFFs=0 -> getInstruction=1, opcodeReg unchanged at 8'h00.
REQ-026 INSTRUCTION mode, instrLastT=7, T6 -> getInstruction=1 forced, seqError=1 after the edge and still 1 after 10 further cycles.
REQ-027 currentAddress=14 at ADDRESS T0 -> noAddressing=1, seqError=1. Then nrst pulse -> seqError=0 and opcodeReg=8'h00.

Source files
------------

// File: rtl/cycle_terminator_if.sv
// Signal bundle between the cycle sequencer and the cycle terminator.
// Fields carry the terminator's port names so both sides connect by name.
interface cycle_terminator_if;
   logic       enableFFs;
   logic       mode;
   logic [2:0] timeState;
   logic [3:0] currentAddress;
   logic [2:0] instrLastT;
   logic       pageCross;
   logic [7:0] dataBus;
   logic       noAddressing;
   logic       endAddressing;
   logic       getInstruction;
   logic [7:0] opcodeReg;
   logic       sync;
   logic       seqError;

   // The sequencer drives phase/cycle information and consumes the terminators.
   modport master (
      output enableFFs, mode, timeState, currentAddress, instrLastT, pageCross, dataBus,
      input  noAddressing, endAddressing, getInstruction, opcodeReg, sync, seqError
   );

   modport slave (
      input  enableFFs, mode, timeState, currentAddress, instrLastT, pageCross, dataBus,
      output noAddressing, endAddressing, getInstruction, opcodeReg, sync, seqError
   );
endinterface

// File: rtl/cycle_terminator.sv
// Decides when the addressing and instruction phases end, inserts the page-cross
// extra cycle, latches the next opcode and flags sequencing faults.
module cycle_terminator #(
   parameter logic ADDRESS     = 1'b0,
   parameter logic INSTRUCTION = 1'b1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       enableFFs,
   input  logic       mode,
   input  logic [2:0] timeState,
   input  logic [3:0] currentAddress,
   input  logic [2:0] instrLastT,
   input  logic       pageCross,
   input  logic [7:0] dataBus,
   output logic       noAddressing,
   output logic       endAddressing,
   output logic       getInstruction,
   output logic [7:0] opcodeReg,
   output logic       sync,
   output logic       seqError
);

   localparam logic [3:0] AM_IMPLIED = 4'd0;
   localparam logic [3:0] AM_ACCUM   = 4'd1;
   localparam logic [3:0] AM_IMM     = 4'd2;
   localparam logic [3:0] AM_ZPG     = 4'd3;
   localparam logic [3:0] AM_ZPG_X   = 4'd4;
   localparam logic [3:0] AM_ZPG_Y   = 4'd5;
   localparam logic [3:0] AM_ABS     = 4'd6;
   localparam logic [3:0] AM_ABS_X   = 4'd7;
   localparam logic [3:0] AM_ABS_Y   = 4'd8;
   localparam logic [3:0] AM_IND     = 4'd9;
   localparam logic [3:0] AM_IND_X   = 4'd10;
   localparam logic [3:0] AM_IND_Y   = 4'd11;
   localparam logic [3:0] AM_REL     = 4'd12;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T6 = 3'd6;

   logic       extra_pending;
   logic       has_base;
   logic [2:0] base_t;
   logic       indexed;
   logic       reserved;
   logic       in_addr;
   logic       in_instr;
   logic       at_base;
   logic       split;
   logic       end_norm;
   logic       get_norm;
   logic       wd_addr;
   logic       wd_instr;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      has_base = 1'b1;
      base_t   = T0;
      unique case (currentAddress)
         AM_IMM, AM_ZPG, AM_REL:                       base_t = 3'd0;
         AM_ZPG_X, AM_ZPG_Y, AM_ABS, AM_ABS_X, AM_ABS_Y: base_t = 3'd1;
         AM_IND_Y:                                     base_t = 3'd2;
         AM_IND, AM_IND_X:                             base_t = 3'd3;
         default:                                      has_base = 1'b0;
      endcase
   end

   assign indexed  = (currentAddress == AM_ABS_X) || (currentAddress == AM_ABS_Y) ||
                     (currentAddress == AM_IND_Y);
   assign reserved = (currentAddress > AM_REL);
   assign in_addr  = (mode == ADDRESS);
   assign in_instr = (mode == INSTRUCTION);

   assign at_base  = in_addr && has_base && (timeState == base_t);
   // A carry at the base cycle defers termination by exactly one cycle.
   assign split    = at_base && indexed && pageCross && !extra_pending;
   assign end_norm = in_addr && (extra_pending || (at_base && !(indexed && pageCross)));
   assign get_norm = in_instr && (timeState == instrLastT);

   // T6 is the last representable cycle; anything still running there is forced to end.
   assign wd_addr  = in_addr  && (timeState == T6) && !end_norm;
   assign wd_instr = in_instr && (timeState == T6) && !get_norm;

   assign noAddressing   = in_addr && (timeState == T0) &&
                           ((currentAddress == AM_IMPLIED) || (currentAddress == AM_ACCUM) || reserved);
   assign endAddressing  = end_norm || wd_addr;
   assign getInstruction = get_norm || wd_instr;
   assign sync           = getInstruction;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         extra_pending <= 1'b0;
         opcodeReg     <= 8'h00;
         seqError      <= 1'b0;
      end else if (enableFFs) begin
         extra_pending <= split;
         if (getInstruction)
            opcodeReg <= dataBus;
         if (wd_addr || wd_instr || (noAddressing && reserved))
            seqError <= 1'b1;
      end
   end

endmodule
